// File: rtl/jtag_pkg.sv
// Shared TAP types: 1149.1 state encoding and the fixed IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    DR_SELECT_SCAN   = 4'h2,
    DR_CAPTURE       = 4'h3,
    DR_SHIFT         = 4'h4,
    DR_EXIT1         = 4'h5,
    DR_PAUSE         = 4'h6,
    DR_EXIT2         = 4'h7,
    DR_UPDATE        = 4'h8,
    IR_SELECT_SCAN   = 4'h9,
    IR_CAPTURE       = 4'hA,
    IR_SHIFT         = 4'hB,
    IR_EXIT1         = 4'hC,
    IR_PAUSE         = 4'hD,
    IR_EXIT2         = 4'hE,
    IR_UPDATE        = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller: registered state plus next-state decode only.
// state               | meaning
// TEST_LOGIC_RESET    | reset, instruction forced to default
// RUN_TEST_IDLE       | idle between scans
// DR_* / IR_*         | select, capture, shift, exit1, pause, exit2, update
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TEST_LOGIC_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tms ? DR_SELECT_SCAN   : RUN_TEST_IDLE;
      DR_SELECT_SCAN:   state_nxt = tms ? IR_SELECT_SCAN   : DR_CAPTURE;
      DR_CAPTURE:       state_nxt = tms ? DR_EXIT1         : DR_SHIFT;
      DR_SHIFT:         state_nxt = tms ? DR_EXIT1         : DR_SHIFT;
      DR_EXIT1:         state_nxt = tms ? DR_UPDATE        : DR_PAUSE;
      DR_PAUSE:         state_nxt = tms ? DR_EXIT2         : DR_PAUSE;
      DR_EXIT2:         state_nxt = tms ? DR_UPDATE        : DR_SHIFT;
      DR_UPDATE:        state_nxt = tms ? DR_SELECT_SCAN   : RUN_TEST_IDLE;
      IR_SELECT_SCAN:   state_nxt = tms ? TEST_LOGIC_RESET : IR_CAPTURE;
      IR_CAPTURE:       state_nxt = tms ? IR_EXIT1         : IR_SHIFT;
      IR_SHIFT:         state_nxt = tms ? IR_EXIT1         : IR_SHIFT;
      IR_EXIT1:         state_nxt = tms ? IR_UPDATE        : IR_PAUSE;
      IR_PAUSE:         state_nxt = tms ? IR_EXIT2         : IR_PAUSE;
      IR_EXIT2:         state_nxt = tms ? IR_UPDATE        : IR_SHIFT;
      IR_UPDATE:        state_nxt = tms ? DR_SELECT_SCAN   : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: FSM, IR, BYPASS/IDCODE DRs, user DR select decode and tdo mux.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register and make it the reset instruction.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int                IR_LEN       = 5,
  parameter int                NUM_USER_DR  = 2,
  parameter logic [IR_LEN-1:0] USER_IR_BASE = 5'h10,
  parameter logic [IR_LEN-1:0] IDCODE_IR    = 5'h01,
  parameter logic [31:0]       IDCODE_VAL   = 32'h1000_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  output logic                   tdo_en,
  output tap_state_t             state,
  output logic [IR_LEN-1:0]      ir,
  output logic                   capture_dr,
  output logic                   shift_dr,
  output logic                   update_dr,
  output logic [NUM_USER_DR-1:0] user_dr_sel,
  input  logic [NUM_USER_DR-1:0] user_dr_tdo
);

  localparam logic [31:0] IDCODE_INIT = IDCODE_VAL | 32'h1;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit                IDCODE_PRESENT = 1'b1;
  localparam logic [IR_LEN-1:0] IR_DEFAULT     = IDCODE_IR;
`else
  localparam bit                IDCODE_PRESENT = 1'b0;
  localparam logic [IR_LEN-1:0] IR_DEFAULT     = '1;
`endif

  logic [IR_LEN-1:0] ir_shift;
  logic              bypass_reg;
  logic              idcode_lsb;
  logic              ir_bypass;
  logic              sel_idcode;

  jtag_tap_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .tms   (tms),
    .state (state)
  );

  assign capture_dr = (state == DR_CAPTURE);
  assign shift_dr   = (state == DR_SHIFT);
  assign update_dr  = (state == DR_UPDATE);
  assign tdo_en     = (state == DR_SHIFT) || (state == IR_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift <= IR_DEFAULT;
    end else if (state == IR_CAPTURE) begin
      ir_shift <= IR_LEN'(IR_CAPTURE_PAT);
    end else if (state == IR_SHIFT) begin
      ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
    end
  end

  // Also load the default on the IR_SELECT_SCAN->TLR edge so ir is already
  // default on the first cycle in TEST_LOGIC_RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= IR_DEFAULT;
    end else if ((state == TEST_LOGIC_RESET) || ((state == IR_SELECT_SCAN) && tms)) begin
      ir <= IR_DEFAULT;
    end else if (state == IR_UPDATE) begin
      ir <= ir_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 bypass_reg <= 1'b0;
    else if (state == DR_CAPTURE) bypass_reg <= 1'b0;
    else if (state == DR_SHIFT)   bypass_reg <= tdi;
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   idcode_sr <= IDCODE_INIT;
    else if (state == DR_CAPTURE) idcode_sr <= IDCODE_INIT;
    else if (state == DR_SHIFT)   idcode_sr <= {tdi, idcode_sr[31:1]};
  end

  assign idcode_lsb = idcode_sr[0];
`else
  // Never selected in this build; tied to a constant.
  assign idcode_lsb = IDCODE_INIT[0];
`endif

  assign ir_bypass  = &ir;
  assign sel_idcode = IDCODE_PRESENT && !ir_bypass && (ir == IDCODE_IR);

  for (genvar k = 0; k < NUM_USER_DR; k++) begin : g_user_sel
    assign user_dr_sel[k] = !ir_bypass && !sel_idcode &&
                            (ir == USER_IR_BASE + IR_LEN'(k));
  end

  always_comb begin
    tdo = 1'b0;
    if (state == IR_SHIFT) begin
      tdo = ir_shift[0];
    end else if (state == DR_SHIFT) begin
      if (sel_idcode)        tdo = idcode_lsb;
      else if (|user_dr_sel) tdo = |(user_dr_sel & user_dr_tdo);
      else                   tdo = bypass_reg;
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed bench for jtag_tap_core with a per-cycle reference model and scan-level literal checks.
module tb_jtag_tap_core;
  import jtag_pkg::*;

  localparam int IRL = 5;
  localparam int NUM = 2;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit         IDC_EN = 1'b1;
  localparam logic [4:0] DEF_IR = 5'h01;
`else
  localparam bit         IDC_EN = 1'b0;
  localparam logic [4:0] DEF_IR = 5'h1F;
`endif

  // TAP transition table: NXT[state][tms]
  localparam int NXT [16][2] = '{
    '{1, 0},  '{1, 2},  '{3, 9},  '{4, 5},
    '{4, 5},  '{6, 8},  '{6, 7},  '{4, 8},
    '{1, 2},  '{10, 0}, '{11, 12}, '{11, 12},
    '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           tdo;
  logic           tdo_en;
  logic [3:0]     state;
  logic [IRL-1:0] ir;
  logic           capture_dr, shift_dr, update_dr;
  logic [NUM-1:0] user_dr_sel;
  logic [NUM-1:0] user_dr_tdo = '0;

  int total = 0;
  int bad = 0;

  jtag_tap_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .state       (state),
    .ir          (ir),
    .capture_dr  (capture_dr),
    .shift_dr    (shift_dr),
    .update_dr   (update_dr),
    .user_dr_sel (user_dr_sel),
    .user_dr_tdo (user_dr_tdo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: -1 bypass, -2 idcode, k >= 0 user DR k
  function automatic int dec(input logic [4:0] v);
    if (v == 5'h1F) return -1;
    if (IDC_EN && v == 5'h01) return -2;
    if (int'(v) >= 16 && int'(v) < 16 + NUM) return int'(v) - 16;
    return -1;
  endfunction

  int          m_st = 0;
  logic [4:0]  m_ir = DEF_IR;
  logic [4:0]  m_irsh = DEF_IR;
  logic        m_byp = 1'b0;
  logic [31:0] m_idc = 32'h1000_0001;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_ir = DEF_IR; m_irsh = DEF_IR; m_byp = 1'b0; m_idc = 32'h1000_0001;
    end else begin
      int ns;
      ns = NXT[m_st][tms];
      if (m_st == 15) m_ir = m_irsh;
      if (ns == 0) m_ir = DEF_IR;
      if (m_st == 10) m_irsh = 5'd1;
      if (m_st == 11) m_irsh = (m_irsh >> 1) | (5'(tdi) << 4);
      if (m_st == 3) begin m_byp = 1'b0; m_idc = 32'h1000_0001; end
      if (m_st == 4) begin m_byp = tdi; m_idc = (m_idc >> 1) | (32'(tdi) << 31); end
      m_st = ns;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_tdo;
      logic [NUM-1:0] exp_sel;
      int d;
      d = dec(m_ir);
      exp_sel = '0;
      if (d >= 0) exp_sel[d] = 1'b1;
      exp_tdo = 1'b0;
      if (m_st == 11) exp_tdo = m_irsh[0];
      else if (m_st == 4) begin
        if (d == -2)      exp_tdo = m_idc[0];
        else if (d >= 0)  exp_tdo = user_dr_tdo[d];
        else              exp_tdo = m_byp;
      end
      chk("state", 32'(state), 32'(m_st));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("tdo", 32'(tdo), 32'(exp_tdo));
      chk("tdo_en", 32'(tdo_en), 32'(m_st == 4 || m_st == 11));
      chk("strobes", {29'd0, capture_dr, shift_dr, update_dr},
          {29'd0, m_st == 3, m_st == 4, m_st == 8});
      chk("user_dr_sel", 32'(user_dr_sel), 32'(exp_sel));
    end
  end

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [4:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i]);
    step(1, 0);
    step(0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_ir"}, 32'(ir), 32'(DEF_IR));
    chk({tag, "_tdo"}, {30'd0, tdo, tdo_en}, 32'h0);
    chk({tag, "_strobes"}, {29'd0, capture_dr, shift_dr, update_dr}, 32'h0);
    chk({tag, "_sel"}, 32'(user_dr_sel), 32'h0);
  endtask

  initial begin
    logic [31:0] idv;
    logic [4:0]  irv;
    logic [3:0]  byv;
    logic [3:0]  bypat;
    logic [5:0]  upat;
    logic [5:0]  uv;

    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // IDCODE scan after reset
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      idv[i] = tdo;
      step(i == 31, 0);
    end
    chk("idcode_scan", idv, IDC_EN ? 32'h1000_0001 : 32'h0);
    step(1, 0); step(0, 0);

    // IR capture pattern and update to 5'h1F
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      irv[i] = tdo;
      step(i == 4, 1);
    end
    chk("ir_capture_bits", 32'(irv), 32'h01);
    step(1, 0); step(0, 0);
    chk("ir_after_update", 32'(ir), 32'h1F);
    chk("sel_bypass", 32'(user_dr_sel), 32'h0);

    // BYPASS delay: tdi 1,0,1,1 -> tdo 0,1,0,1
    bypat = 4'b1101;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      byv[i] = tdo;
      step(i == 3, bypat[i]);
    end
    chk("bypass_delay", 32'(byv), 32'(4'b1010));
    step(1, 0); step(0, 0);

    // User DR 1 select and tdo routing
    load_ir(5'h11);
    chk("user_sel", 32'(user_dr_sel), 32'(2'b10));
    upat = 6'b101100;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 6; i++) begin
      user_dr_tdo = {upat[i], ~upat[i]};
      #1;
      uv[i] = tdo;
      step(i == 5, 0);
    end
    chk("user_tdo", 32'(uv), 32'(upat));
    user_dr_tdo = '0;

    // Five tms=1 edges from DR_PAUSE
    step(0, 0); step(0, 0);
    chk("in_dr_pause", 32'(state), 32'h6);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms_reset_state", 32'(state), 32'h0);
    chk("tms_reset_ir", 32'(ir), 32'(DEF_IR));

    // Async reset in the middle of an IR scan
    step(0, 0);
    load_ir(5'h10);
    chk("ir_user0", 32'(user_dr_sel), 32'(2'b01));
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0); step(0, 0); step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
